// File: rtl/rca_operand_sequencer_if.sv
// rca_operand_sequencer_if: operand, adder and result handshake bundle for the RCA sequencer
interface rca_operand_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             inValid;
    logic             inReady;
    logic [WIDTH-1:0] inA;
    logic [WIDTH-1:0] inB;
    logic             inCin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cIn;
    logic             En;
    logic [WIDTH-1:0] sUm;
    logic             cOut;
    logic             resValid;
    logic             resReady;
    logic [WIDTH-1:0] resSum;
    logic             resCout;
    logic             resOvf;

    modport master (
        output inValid, inA, inB, inCin, sUm, cOut, resReady,
        input  inReady, a, b, cIn, En, resValid, resSum, resCout, resOvf
    );

    modport slave (
        input  inValid, inA, inB, inCin, sUm, cOut, resReady,
        output inReady, a, b, cIn, En, resValid, resSum, resCout, resOvf
    );
endinterface

// File: rtl/rca_operand_sequencer.sv
// rca_operand_sequencer: registers operands onto the adder, waits for the carry chain, returns the result
module rca_operand_sequencer #(
    parameter int WIDTH         = 16,
    parameter int SETTLE_CYCLES = 4
) (
    input logic                   Clk,
    input logic                   Rs,
    rca_operand_sequencer_if.slave io
);
    typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

    localparam logic [7:0] CNT_INIT = 8'(SETTLE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_sum_q, res_sum_d;
    logic             cin_q, cin_d, en_q, en_d;
    logic             res_cout_q, res_cout_d, res_ovf_q, res_ovf_d, res_valid_q, res_valid_d;
    logic             ovf;

    assign ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (io.sUm[WIDTH-1] != a_q[WIDTH-1]);

    // Next-state: accept in IDLE, count down while the carry chain settles, hold until consumed
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        cin_d       = cin_q;
        en_d        = en_q;
        res_sum_d   = res_sum_q;
        res_cout_d  = res_cout_q;
        res_ovf_d   = res_ovf_q;
        res_valid_d = res_valid_q;
        unique case (state_q)
            IDLE: if (io.inValid) begin
                a_d     = io.inA;
                b_d     = io.inB;
                cin_d   = io.inCin;
                cnt_d   = CNT_INIT;
                en_d    = 1'b1;
                state_d = SETTLE;
            end
            SETTLE: if (cnt_q != 8'd0) begin
                cnt_d = cnt_q - 8'd1;
            end else begin
                res_sum_d   = io.sUm;
                res_cout_d  = io.cOut;
                res_ovf_d   = ovf;
                res_valid_d = 1'b1;
                en_d        = 1'b0;
                state_d     = DONE;
            end
            DONE: if (io.resReady) begin
                res_valid_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset overrides any handshake in the same cycle
    always_ff @(posedge Clk) begin
        if (Rs) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            cin_q       <= 1'b0;
            en_q        <= 1'b0;
            res_sum_q   <= '0;
            res_cout_q  <= 1'b0;
            res_ovf_q   <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cin_q       <= cin_d;
            en_q        <= en_d;
            res_sum_q   <= res_sum_d;
            res_cout_q  <= res_cout_d;
            res_ovf_q   <= res_ovf_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign io.inReady  = (state_q == IDLE);
    assign io.a        = a_q;
    assign io.b        = b_q;
    assign io.cIn      = cin_q;
    assign io.En       = en_q;
    assign io.resValid = res_valid_q;
    assign io.resSum   = res_sum_q;
    assign io.resCout  = res_cout_q;
    assign io.resOvf   = res_ovf_q;
endmodule

// File: tb/tb_rca_operand_sequencer.sv
// tb_rca_operand_sequencer: directed checks of the sequencer around a behavioural 16-bit adder
module tb_rca_operand_sequencer;
    logic Clk = 1'b0;
    logic Rs;
    int   checks   = 0;
    int   failures = 0;

    rca_operand_sequencer_if #(.WIDTH(16)) io0 ();
    rca_operand_sequencer_if #(.WIDTH(16)) io1 ();

    assign {io0.cOut, io0.sUm} = {1'b0, io0.a} + {1'b0, io0.b} + {16'd0, io0.cIn};
    assign {io1.cOut, io1.sUm} = {1'b0, io1.a} + {1'b0, io1.b} + {16'd0, io1.cIn};

    rca_operand_sequencer #(.WIDTH(16), .SETTLE_CYCLES(4)) dut0 (.Clk(Clk), .Rs(Rs), .io(io0));
    rca_operand_sequencer #(.WIDTH(16), .SETTLE_CYCLES(1)) dut1 (.Clk(Clk), .Rs(Rs), .io(io1));

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Waits for resValid on dut0 and returns the number of edges taken (99 on timeout)
    task automatic wait_res(output int lat);
        lat = 99;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (io0.resValid === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic [15:0] es, input logic ec, input logic eo);
        int lat;
        io0.inValid = 1'b1;
        io0.inA     = a;
        io0.inB     = b;
        io0.inCin   = cin;
        tick();
        io0.inValid = 1'b0;
        chk({tag, "_en"}, 32'(io0.En), 32'd1);
        chk({tag, "_a"}, 32'(io0.a), 32'(a));
        wait_res(lat);
        chk({tag, "_lat"}, 32'(lat), 32'd4);
        chk({tag, "_sum"}, 32'(io0.resSum), 32'(es));
        chk({tag, "_cout"}, 32'(io0.resCout), 32'(ec));
        chk({tag, "_ovf"}, 32'(io0.resOvf), 32'(eo));
        chk({tag, "_en_off"}, 32'(io0.En), 32'd0);
        io0.resReady = 1'b1;
        tick();
        io0.resReady = 1'b0;
        chk({tag, "_idle"}, 32'(io0.inReady), 32'd1);
        chk({tag, "_drop"}, 32'(io0.resValid), 32'd0);
    endtask

    initial begin
        int lat;
        logic [15:0] ra, rb;
        logic        rc;
        logic [16:0] rexp;
        Rs = 1'b1;
        io0.inValid = 1'b0; io0.inA = '0; io0.inB = '0; io0.inCin = 1'b0; io0.resReady = 1'b0;
        io1.inValid = 1'b0; io1.inA = '0; io1.inB = '0; io1.inCin = 1'b0; io1.resReady = 1'b1;
        tick();
        tick();
        Rs = 1'b0;
        chk("rst_ready", 32'(io0.inReady), 32'd1);
        chk("rst_valid", 32'(io0.resValid), 32'd0);
        chk("rst_outs", {io0.a, io0.b}, 32'd0);
        chk("rst_misc", {io0.cIn, io0.En, io0.resCout, io0.resOvf, io0.resSum}, 32'd0);
        do_op("t1", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        do_op("t2a", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        // Overflow looks only at the operand and sum MSBs, so 7FFF+0+cin still flags it
        do_op("t2b", 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1);
        do_op("t3a", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_op("t3b", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        // Backpressure with a competing operand pair presented during DONE
        io0.inValid = 1'b1; io0.inA = 16'h1111; io0.inB = 16'h2222; io0.inCin = 1'b0;
        tick();
        io0.inValid = 1'b0;
        wait_res(lat);
        chk("bp_lat", 32'(lat), 32'd4);
        io0.inValid = 1'b1; io0.inA = 16'hAAAA; io0.inB = 16'h5555; io0.inCin = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_sum", 32'(io0.resSum), 32'h3333);
            chk("bp_valid", 32'(io0.resValid), 32'd1);
            chk("bp_ready", 32'(io0.inReady), 32'd0);
            chk("bp_ab", {io0.a, io0.b}, 32'h11112222);
        end
        io0.resReady = 1'b1;
        tick();
        io0.resReady = 1'b0;
        chk("bp_idle", 32'(io0.inReady), 32'd1);
        chk("bp_drop", 32'(io0.resValid), 32'd0);
        tick();
        io0.inValid = 1'b0;
        chk("bp_accept_ab", {io0.a, io0.b}, 32'hAAAA5555);
        chk("bp_accept_en", 32'(io0.En), 32'd1);
        wait_res(lat);
        chk("bp2_lat", 32'(lat), 32'd4);
        chk("bp2_sum", {io0.resCout, io0.resOvf, io0.resSum}, 32'h0FFFF);
        io0.resReady = 1'b1;
        tick();
        io0.resReady = 1'b0;
        // Reset in the second SETTLE cycle abandons the operation
        io0.inValid = 1'b1; io0.inA = 16'h0F0F; io0.inB = 16'h0101; io0.inCin = 1'b1;
        tick();
        io0.inValid = 1'b0;
        tick();
        Rs = 1'b1;
        tick();
        Rs = 1'b0;
        chk("rs_ab", {io0.a, io0.b}, 32'd0);
        chk("rs_misc", {io0.cIn, io0.En, io0.resValid, io0.resCout, io0.resOvf, io0.resSum}, 32'd0);
        chk("rs_ready", 32'(io0.inReady), 32'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rs_no_valid", 32'(io0.resValid), 32'd0);
        end
        do_op("t5", 16'h0F0F, 16'h0101, 1'b1, 16'h1011, 1'b0, 1'b0);
        // Single-cycle settle: 100 random pairs, one op every three clocks
        for (int i = 0; i < 100; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            rexp = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
            io1.inValid = 1'b1; io1.inA = ra; io1.inB = rb; io1.inCin = rc;
            tick();
            io1.inValid = 1'b0;
            chk("r_busy", 32'(io1.resValid), 32'd0);
            tick();
            chk("r_valid", 32'(io1.resValid), 32'd1);
            chk("r_res", {io1.resCout, io1.resSum}, 32'(rexp));
            chk("r_ovf", 32'(io1.resOvf), 32'((ra[15] == rb[15]) && (rexp[15] != ra[15])));
            tick();
            chk("r_idle", 32'(io1.inReady), 32'd1);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
